// File: rtl/arm_alu_regfile.sv
// arm_alu_regfile: 16x32 register file (R15 = PC) feeding a combinational ARM-style ALU
// Ports:
//   Clk, RESET       clock, asynchronous active-high reset (clears all registers)
//   Pcin, LOADPC     PC load value and its write enable into R15
//   RSLCT            [3:0] Rn(IR), [7:4] Rm, [11:8] Rs, [15:12] Rd, [19:16] Rn(CU)
//   IR_CU            1 selects Rn from RSLCT[3:0], 0 from RSLCT[19:16]
//   LOAD             write Out into R[Rd]
//   OP, FLAGS, S     ALU opcode, incoming NZCV, flag update enable
//   ALU_OUT          ALU result output enable (0 forces Out and write data to 0)
//   Rn, Rm, Rs       read-port data
//   PCout            R15 contents
//   Out, FLAGS_OUT   ALU result / write data, NZCV result
// Build option: define ALU_MUL_EN to make OP=20 a 32-bit low-half multiply.
module arm_alu_regfile (
   input  logic        Clk,
   input  logic        RESET,
   input  logic [31:0] Pcin,
   input  logic [19:0] RSLCT,
   input  logic        LOADPC,
   input  logic        LOAD,
   input  logic        IR_CU,
   input  logic [4:0]  OP,
   input  logic [3:0]  FLAGS,
   input  logic        S,
   input  logic        ALU_OUT,
   output logic [31:0] Rn,
   output logic [31:0] Rm,
   output logic [31:0] Rs,
   output logic [31:0] PCout,
   output logic [31:0] Out,
   output logic [3:0]  FLAGS_OUT
);
   logic [31:0] r [16];
   logic [3:0]  rn_sel;
   logic [31:0] x, y, res;
   logic [32:0] sum;
   logic        ci, ar, v;

   assign rn_sel = IR_CU ? RSLCT[3:0] : RSLCT[19:16];
   assign Rn     = r[rn_sel];
   assign Rm     = r[RSLCT[7:4]];
   assign Rs     = r[RSLCT[11:8]];
   assign PCout  = r[15];

   // The PC load is placed last so it overrides a LOAD that also targets R15.
   always_ff @(posedge Clk or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < 16; i++) r[i] <= '0;
      end else begin
         if (LOAD) r[RSLCT[15:12]] <= Out;
         if (LOADPC) r[15] <= Pcin;
      end
   end

   // Every arithmetic op is x + y + ci; subtracts invert one operand so C = NOT borrow.
   always_comb begin
      x  = Rn;
      y  = Rm;
      ci = 1'b0;
      ar = 1'b1;
      case (OP)
         5'd2, 5'd10: begin y = ~Rm; ci = 1'b1; end
         5'd3:        begin x = Rm; y = ~Rn; ci = 1'b1; end
         5'd5:        ci = FLAGS[1];
         5'd6:        begin y = ~Rm; ci = FLAGS[1]; end
         5'd7:        begin x = Rm; y = ~Rn; ci = FLAGS[1]; end
         5'd16:       y = 32'd4;
         5'd19:       begin x = Rm; y = 32'd4; end
         5'd4, 5'd11: ;
         default:     ar = 1'b0;
      endcase
      sum = {1'b0, x} + {1'b0, y} + {32'd0, ci};
      v   = (x[31] == y[31]) && (sum[31] != x[31]);
      case (OP)
         5'd0, 5'd8: res = Rn & Rm;
         5'd1, 5'd9: res = Rn ^ Rm;
         5'd12:      res = Rn | Rm;
         5'd13:      res = Rm;
         5'd14:      res = Rn & ~Rm;
         5'd15:      res = ~Rm;
         5'd17:      res = Rn;
         5'd18:      res = Rm;
`ifdef ALU_MUL_EN
         5'd20:      res = Rn * Rm;
`endif
         default:    res = ar ? sum[31:0] : 32'd0;
      endcase
   end

   assign Out       = ALU_OUT ? res : 32'd0;
   assign FLAGS_OUT = S ? {res[31], res == 32'd0, ar ? sum[32] : FLAGS[1], ar ? v : FLAGS[0]} : FLAGS;
endmodule

// File: tb/tb_arm_alu_regfile.sv
// tb_arm_alu_regfile: directed vector table plus reset sequences for arm_alu_regfile
module tb_arm_alu_regfile;
   logic        Clk = 1'b0;
   logic        RESET, LOADPC, LOAD, IR_CU, S, ALU_OUT;
   logic [31:0] Pcin, Rn, Rm, Rs, PCout, Out;
   logic [19:0] RSLCT;
   logic [4:0]  OP;
   logic [3:0]  FLAGS, FLAGS_OUT;
   int          n = 0;
   int          fails = 0;

   arm_alu_regfile dut (
      .Clk(Clk), .RESET(RESET), .Pcin(Pcin), .RSLCT(RSLCT), .LOADPC(LOADPC), .LOAD(LOAD),
      .IR_CU(IR_CU), .OP(OP), .FLAGS(FLAGS), .S(S), .ALU_OUT(ALU_OUT),
      .Rn(Rn), .Rm(Rm), .Rs(Rs), .PCout(PCout), .Out(Out), .FLAGS_OUT(FLAGS_OUT)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic        ir;
      logic [3:0]  rn, rm, rs, rd, cu;
      logic [4:0]  op;
      logic [3:0]  fl;
      logic        s, ao, ld, lp;
      logic [31:0] pcin, eo;
      logic [3:0]  ef;
      logic [31:0] ep, er;
   } vec_t;

   vec_t q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   localparam logic [31:0] P = 32'h7FFFFFFF;

   initial begin
      //            ir rn  rm  rs  rd  cu  op     fl       s  ao ld lp pcin          eo             ef       ep        er
      q.push_back('{1, 0,  0,  1,  1,  0,  17, 4'b0000, 0, 1, 1, 0, 32'h0,        32'h0,         4'b0000, 32'h0,    32'h0});
      q.push_back('{1, 0,  0,  15, 0,  0,  17, 4'b0000, 0, 1, 0, 1, 32'h100,      32'h0,         4'b0000, 32'h100,  32'h100});
      q.push_back('{0, 0,  0,  15, 15, 15, 16, 4'b0000, 1, 1, 1, 0, 32'h0,        32'h104,       4'b0000, 32'h104,  32'h104});
      q.push_back('{0, 0,  0,  2,  2,  15, 17, 4'b0000, 0, 1, 1, 0, 32'h0,        32'h104,       4'b0000, 32'h104,  32'h104});
      q.push_back('{1, 2,  15, 3,  3,  0,  4,  4'b0000, 0, 1, 1, 0, 32'h0,        32'h208,       4'b0000, 32'h104,  32'h208});
      q.push_back('{1, 2,  2,  3,  0,  0,  2,  4'b0000, 1, 1, 0, 0, 32'h0,        32'h0,         4'b0110, 32'h104,  32'h208});
      q.push_back('{1, 2,  2,  3,  0,  0,  2,  4'b1001, 0, 1, 0, 0, 32'h0,        32'h0,         4'b1001, 32'h104,  32'h208});
      q.push_back('{1, 0,  0,  4,  4,  0,  15, 4'b0000, 1, 1, 1, 0, 32'h0,        32'hFFFFFFFF,  4'b1000, 32'h104,  32'hFFFFFFFF});
      q.push_back('{1, 0,  4,  5,  5,  0,  2,  4'b0000, 1, 1, 1, 0, 32'h0,        32'h1,         4'b0000, 32'h104,  32'h1});
      q.push_back('{1, 0,  0,  15, 0,  0,  17, 4'b0000, 0, 1, 0, 1, P,            32'h0,         4'b0000, P,        P});
      q.push_back('{0, 0,  0,  6,  6,  15, 17, 4'b0000, 0, 1, 1, 0, 32'h0,        P,             4'b0000, P,        P});
      q.push_back('{1, 6,  5,  6,  0,  0,  4,  4'b0000, 1, 1, 0, 0, 32'h0,        32'h80000000,  4'b1001, P,        P});
      q.push_back('{1, 6,  5,  4,  4,  0,  4,  4'b0000, 0, 0, 1, 0, 32'h0,        32'h0,         4'b0000, P,        32'h0});
      q.push_back('{1, 6,  5,  6,  0,  0,  5,  4'b0010, 1, 1, 0, 0, 32'h0,        32'h80000001,  4'b1001, P,        P});
      q.push_back('{1, 5,  6,  6,  0,  0,  6,  4'b0000, 1, 1, 0, 0, 32'h0,        32'h80000001,  4'b1000, P,        P});
      q.push_back('{1, 5,  6,  6,  0,  0,  3,  4'b0000, 1, 1, 0, 0, 32'h0,        32'h7FFFFFFE,  4'b0010, P,        P});
      q.push_back('{1, 6,  5,  6,  0,  0,  0,  4'b0011, 1, 1, 0, 0, 32'h0,        32'h1,         4'b0011, P,        P});
      q.push_back('{1, 6,  6,  6,  0,  0,  1,  4'b0000, 1, 1, 0, 0, 32'h0,        32'h0,         4'b0100, P,        P});
      q.push_back('{1, 5,  15, 6,  0,  0,  12, 4'b0000, 1, 1, 0, 0, 32'h0,        P,             4'b0000, P,        P});
      q.push_back('{1, 6,  5,  6,  0,  0,  14, 4'b0010, 1, 1, 0, 0, 32'h0,        32'h7FFFFFFE,  4'b0010, P,        P});
      q.push_back('{1, 0,  5,  6,  0,  0,  13, 4'b0000, 1, 1, 0, 0, 32'h0,        32'h1,         4'b0000, P,        P});
      q.push_back('{1, 0,  6,  6,  0,  0,  18, 4'b0000, 1, 1, 0, 0, 32'h0,        P,             4'b0000, P,        P});
      q.push_back('{1, 0,  6,  6,  0,  0,  19, 4'b0000, 1, 1, 0, 0, 32'h0,        32'h80000003,  4'b1001, P,        P});
      q.push_back('{1, 5,  6,  6,  0,  0,  10, 4'b0000, 1, 1, 0, 0, 32'h0,        32'h80000002,  4'b1000, P,        P});
      q.push_back('{1, 5,  6,  6,  0,  0,  21, 4'b0000, 1, 1, 0, 0, 32'h0,        32'h0,         4'b0100, P,        P});
      q.push_back('{1, 5,  6,  6,  0,  0,  20, 4'b0011, 1, 1, 0, 0, 32'h0,        32'h0,         4'b0111, P,        P});
      q.push_back('{1, 6,  5,  8,  8,  0,  8,  4'b0000, 0, 1, 1, 0, 32'h0,        32'h1,         4'b0000, P,        32'h1});
      q.push_back('{1, 5,  0,  15, 15, 0,  17, 4'b0000, 0, 1, 1, 1, 32'h40,       32'h1,         4'b0000, 32'h40,   32'h40});
      q.push_back('{1, 6,  0,  9,  9,  0,  17, 4'b0000, 0, 1, 1, 1, 32'h200,      P,             4'b0000, 32'h200,  P});

      RESET = 1'b1; LOADPC = 1'b1; LOAD = 1'b1; IR_CU = 1'b1; S = 1'b0; ALU_OUT = 1'b1;
      Pcin = 32'hABC; RSLCT = 20'hF0F0F; OP = 5'd18; FLAGS = 4'b0000;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("reset Rn", Rn, 32'h0);
      chk("reset Rm", Rm, 32'h0);
      chk("reset Rs", Rs, 32'h0);
      chk("reset PCout", PCout, 32'h0);
      RESET = 1'b0; LOADPC = 1'b0; LOAD = 1'b0;

      for (int i = 0; i < q.size(); i++) begin
         @(negedge Clk);
         IR_CU = q[i].ir; OP = q[i].op; FLAGS = q[i].fl; S = q[i].s; ALU_OUT = q[i].ao;
         LOAD = q[i].ld; LOADPC = q[i].lp; Pcin = q[i].pcin;
         RSLCT = {q[i].cu, q[i].rd, q[i].rs, q[i].rm, q[i].rn};
         #1;
         chk($sformatf("v%0d Out", i), Out, q[i].eo);
         chk($sformatf("v%0d FLAGS_OUT", i), {28'd0, FLAGS_OUT}, {28'd0, q[i].ef});
         @(posedge Clk);
         #1;
         chk($sformatf("v%0d PCout", i), PCout, q[i].ep);
         chk($sformatf("v%0d Rs", i), Rs, q[i].er);
         LOAD = 1'b0; LOADPC = 1'b0;
      end

      @(negedge Clk);
      RSLCT = 20'h00900; LOAD = 1'b1; LOADPC = 1'b1; Pcin = 32'h55; OP = 5'd17;
      RESET = 1'b1;
      #1;
      chk("async reset PCout", PCout, 32'h0);
      chk("async reset R9", Rs, 32'h0);
      @(posedge Clk);
      #1;
      chk("write under reset PCout", PCout, 32'h0);
      @(negedge Clk);
      RESET = 1'b0; LOAD = 1'b0; LOADPC = 1'b0;
      #1;
      chk("post reset PCout", PCout, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n, fails);
      $finish;
   end
endmodule
